// File: rtl/oport_credit_ctrl.sv
// -----------------------------------------------------------------------------
// oport_credit_ctrl
//   Per-output-port virtual-channel credit and allocation tracker. Sits between
//   the VC/switch allocator and the crossbar/link of one router output port.
//   Tracks downstream buffer credits per VC, runs a per-VC allocation state
//   machine (FREE / ALLOC / DRAIN) for atomic or non-atomic VC reallocation,
//   and publishes a registered congestion index.
//
// Parameters
//   V                     VCs per port
//   B                     downstream buffer depth per VC in flits (B >= 2)
//   LINK_DELAY            register stages applied to credit_in (0..4)
//   VC_REALLOCATION_TYPE  "ATOMIC" or "NONATOMIC"
//   CONGw                 width of congestion_out
//   Bw                    counter width, derived from B
//
// Ports
//   clk             clock
//   reset           asynchronous active-high reset
//   flit_out_we     a flit is written to the link this cycle
//   flit_out_vc     one-hot VC of that flit
//   flit_out_tail   that flit is a tail
//   ovc_alloc       one-hot VC granted by the VC allocator (zero = none)
//   credit_in       per-VC credit returned by the downstream router
//   ovc_not_full    VC holds at least one credit
//   ovc_free        VC is available for allocation
//   credit_cnt_all  all credit counters, VC0 in the LSBs
//   congestion_out  registered, saturated count of non-FREE VCs
//   err             sticky protocol error flag
// -----------------------------------------------------------------------------
module oport_credit_ctrl #(
    parameter int    V                    = 4,
    parameter int    B                    = 4,
    parameter int    LINK_DELAY           = 0,
    parameter string VC_REALLOCATION_TYPE = "NONATOMIC",
    parameter int    CONGw                = 3,
    localparam int   Bw                   = $clog2(B + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flit_out_we,
    input  logic [V-1:0]        flit_out_vc,
    input  logic                flit_out_tail,
    input  logic [V-1:0]        ovc_alloc,
    input  logic [V-1:0]        credit_in,
    output logic [V-1:0]        ovc_not_full,
    output logic [V-1:0]        ovc_free,
    output logic [V*Bw-1:0]     credit_cnt_all,
    output logic [CONGw-1:0]    congestion_out,
    output logic                err
);

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam bit            IS_ATOMIC = (VC_REALLOCATION_TYPE == "ATOMIC");
    localparam int            CONG_MAX  = (1 << CONGw) - 1;
    localparam logic [Bw-1:0] CNT_FULL  = Bw'(B);

    logic [V-1:0]     w_credit_d;
    logic [V-1:0]     w_alloc;
    logic [V-1:0]     w_busy;
    logic [V-1:0]     w_vc_err;
    logic             w_vc_bad;
    logic             w_write;
    logic             w_alloc_bad;
    int               w_busy_cnt;
    logic [CONGw-1:0] r_cong;
    logic             r_err;

    // A multi-hot write VC freezes every counter (credits included) and the
    // write is treated as absent by the state machines.
    assign w_vc_bad    = flit_out_we && ($countones(flit_out_vc) > 1);
    assign w_write     = flit_out_we && !w_vc_bad;
    // A multi-hot grant is flagged and otherwise ignored.
    assign w_alloc_bad = ($countones(ovc_alloc) > 1);
    assign w_alloc     = w_alloc_bad ? '0 : ovc_alloc;

    // ---------------------------------------------------------------- credit delay
    generate
        if (LINK_DELAY == 0) begin : g_no_delay
            assign w_credit_d = credit_in;
        end else begin : g_delay
            logic [V-1:0] r_pipe [LINK_DELAY];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < LINK_DELAY; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= credit_in;
                    for (int i = 1; i < LINK_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_credit_d = r_pipe[LINK_DELAY-1];
        end
    endgenerate

    // ---------------------------------------------------------------- per-VC logic
    genvar gi;
    generate
        for (gi = 0; gi < V; gi++) begin : g_vc
            logic [Bw-1:0] r_cnt;
            logic [Bw-1:0] w_cnt_next;
            state_t        r_state;
            state_t        w_state_next;
            logic          w_dec;
            logic          w_inc;
            logic          w_tail;
            logic          w_al;
            logic          w_cnt_err;
            logic          w_fsm_err;

            assign w_dec  = w_write & flit_out_vc[gi];
            assign w_inc  = w_credit_d[gi] & ~w_vc_bad;
            assign w_tail = w_dec & flit_out_tail;
            assign w_al   = w_alloc[gi];

            // Simultaneous write and credit cancel out; over/underflow saturates.
            always_comb begin
                w_cnt_next = r_cnt;
                w_cnt_err  = 1'b0;
                if (w_dec && !w_inc) begin
                    if (r_cnt == '0) w_cnt_err  = 1'b1;
                    else             w_cnt_next = r_cnt - 1'b1;
                end else if (w_inc && !w_dec) begin
                    if (r_cnt == CNT_FULL) w_cnt_err  = 1'b1;
                    else                   w_cnt_next = r_cnt + 1'b1;
                end
            end

            always_comb begin
                w_state_next = r_state;
                w_fsm_err    = 1'b0;
                case (r_state)
                    ST_FREE: begin
                        if (w_dec) w_fsm_err = 1'b1;
                        if (w_al)  w_state_next = ST_ALLOC;
                    end
                    ST_ALLOC: begin
                        if (w_tail) begin
                            if (IS_ATOMIC) begin
                                // Skip DRAIN if every credit is already back.
                                if (w_al) w_fsm_err = 1'b1;
                                w_state_next = (w_cnt_next == CNT_FULL) ? ST_FREE : ST_DRAIN;
                            end else begin
                                // A grant coinciding with the tail is a hand-over.
                                w_state_next = w_al ? ST_ALLOC : ST_FREE;
                            end
                        end else if (w_al) begin
                            w_fsm_err = 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        if (w_al) w_fsm_err = 1'b1;
                        if (w_cnt_next == CNT_FULL) w_state_next = ST_FREE;
                    end
                    default: w_state_next = ST_FREE;
                endcase
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt   <= CNT_FULL;
                    r_state <= ST_FREE;
                end else begin
                    r_cnt   <= w_cnt_next;
                    r_state <= w_state_next;
                end
            end

            assign w_vc_err[gi]                  = w_cnt_err | w_fsm_err;
            assign w_busy[gi]                    = (r_state != ST_FREE);
            assign ovc_not_full[gi]              = (r_cnt != '0);
            assign ovc_free[gi]                  = (r_state == ST_FREE);
            assign credit_cnt_all[gi*Bw +: Bw]   = r_cnt;
        end
    endgenerate

    // ---------------------------------------------------------------- congestion / error
    assign w_busy_cnt = $countones(w_busy);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cong <= '0;
            r_err  <= 1'b0;
        end else begin
            r_cong <= (w_busy_cnt > CONG_MAX) ? CONGw'(CONG_MAX) : CONGw'(w_busy_cnt);
            r_err  <= r_err | (|w_vc_err) | w_vc_bad | w_alloc_bad;
        end
    end

    assign congestion_out = r_cong;
    assign err            = r_err;

endmodule

// File: tb/tb_oport_credit_ctrl.sv
module tb_oport_credit_ctrl;

    localparam int V  = 4;
    localparam int B  = 4;
    localparam int BW = 3;
    localparam int M_FREE  = 0;
    localparam int M_ALLOC = 1;
    localparam int M_DRAIN = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         we;
    logic [V-1:0] vc;
    logic         tail;
    logic [V-1:0] alloc;
    logic [V-1:0] credit;

    logic [V-1:0]    nf0, free0, nf1, free1;
    logic [V*BW-1:0] cnt0, cnt1;
    logic [2:0]      cong0;
    logic [1:0]      cong1;
    logic            err0, err1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Config 0: non-atomic, no link delay, 3-bit congestion.
    oport_credit_ctrl #(.V(V), .B(B), .LINK_DELAY(0),
                        .VC_REALLOCATION_TYPE("NONATOMIC"), .CONGw(3)) dut0 (
        .clk(clk), .reset(reset), .flit_out_we(we), .flit_out_vc(vc),
        .flit_out_tail(tail), .ovc_alloc(alloc), .credit_in(credit),
        .ovc_not_full(nf0), .ovc_free(free0), .credit_cnt_all(cnt0),
        .congestion_out(cong0), .err(err0));

    // Config 1: atomic, two-stage link delay, 2-bit congestion.
    oport_credit_ctrl #(.V(V), .B(B), .LINK_DELAY(2),
                        .VC_REALLOCATION_TYPE("ATOMIC"), .CONGw(2)) dut1 (
        .clk(clk), .reset(reset), .flit_out_we(we), .flit_out_vc(vc),
        .flit_out_tail(tail), .ovc_alloc(alloc), .credit_in(credit),
        .ovc_not_full(nf1), .ovc_free(free1), .credit_cnt_all(cnt1),
        .congestion_out(cong1), .err(err1));

    // ------------------------------------------------------------ reference model
    int           m_cnt  [2][V];
    int           m_st   [2][V];
    bit           m_err  [2];
    int           m_cong [2];
    logic [V-1:0] m_dq0 [$];
    logic [V-1:0] m_dq1 [$];
    int           cfg_cmax   [2] = '{7, 3};
    bit           cfg_atomic [2] = '{1'b0, 1'b1};

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int v = 0; v < V; v++) begin
                m_cnt[c][v] = B;
                m_st[c][v]  = M_FREE;
            end
            m_err[c]  = 1'b0;
            m_cong[c] = 0;
        end
        m_dq0.delete();
        m_dq1.delete();
        m_dq1.push_back('0);
        m_dq1.push_back('0);
    endtask

    task automatic model_step(input logic w, input logic [V-1:0] wv, input logic t,
                              input logic [V-1:0] a_in, input logic [V-1:0] cr);
        logic [V-1:0] cd, a;
        bit vc_bad, a_bad, wr, tl, ci, al;
        int busy, nc;
        vc_bad = w && ($countones(wv) > 1);
        a_bad  = ($countones(a_in) > 1);
        a      = a_bad ? '0 : a_in;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin m_dq0.push_back(cr); cd = m_dq0.pop_front(); end
            else        begin m_dq1.push_back(cr); cd = m_dq1.pop_front(); end
            busy = 0;
            for (int v = 0; v < V; v++) if (m_st[c][v] != M_FREE) busy++;
            m_cong[c] = (busy > cfg_cmax[c]) ? cfg_cmax[c] : busy;
            if (vc_bad || a_bad) m_err[c] = 1'b1;
            for (int v = 0; v < V; v++) begin
                wr = w && !vc_bad && wv[v];
                tl = wr && t;
                ci = cd[v] && !vc_bad;
                al = a[v];
                nc = m_cnt[c][v];
                if (wr && !ci) begin
                    if (nc == 0) m_err[c] = 1'b1; else nc--;
                end else if (ci && !wr) begin
                    if (nc == B) m_err[c] = 1'b1; else nc++;
                end
                if (m_st[c][v] == M_FREE) begin
                    if (wr) m_err[c] = 1'b1;
                    if (al) m_st[c][v] = M_ALLOC;
                end else if (m_st[c][v] == M_ALLOC) begin
                    if (tl && cfg_atomic[c]) begin
                        if (al) m_err[c] = 1'b1;
                        m_st[c][v] = (nc == B) ? M_FREE : M_DRAIN;
                    end else if (tl) begin
                        m_st[c][v] = al ? M_ALLOC : M_FREE;
                    end else if (al) begin
                        m_err[c] = 1'b1;
                    end
                end else begin
                    if (al) m_err[c] = 1'b1;
                    if (nc == B) m_st[c][v] = M_FREE;
                end
                m_cnt[c][v] = nc;
            end
        end
    endtask

    // ------------------------------------------------------------ checking
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [V-1:0]    e_nf, e_free;
        logic [V*BW-1:0] e_cnt;
        for (int c = 0; c < 2; c++) begin
            for (int v = 0; v < V; v++) begin
                e_nf[v]            = (m_cnt[c][v] != 0);
                e_free[v]          = (m_st[c][v] == M_FREE);
                e_cnt[v*BW +: BW]  = BW'(m_cnt[c][v]);
            end
            if (c == 0) begin
                check("m0_not_full", 32'(nf0), 32'(e_nf));
                check("m0_free", 32'(free0), 32'(e_free));
                check("m0_cnt", 32'(cnt0), 32'(e_cnt));
                check("m0_cong", 32'(cong0), 32'(m_cong[0]));
                check("m0_err", 32'(err0), 32'(m_err[0]));
            end else begin
                check("m1_not_full", 32'(nf1), 32'(e_nf));
                check("m1_free", 32'(free1), 32'(e_free));
                check("m1_cnt", 32'(cnt1), 32'(e_cnt));
                check("m1_cong", 32'(cong1), 32'(m_cong[1]));
                check("m1_err", 32'(err1), 32'(m_err[1]));
            end
        end
    endtask

    // Inputs are applied #1 after an edge; outputs are checked #1 after the next.
    task automatic step(input logic w, input logic [V-1:0] wv, input logic t,
                        input logic [V-1:0] a, input logic [V-1:0] cr);
        we = w; vc = wv; tail = t; alloc = a; credit = cr;
        model_step(w, wv, t, a, cr);
        @(posedge clk);
        #1;
        $display("step we=%0b vc=%b tail=%0b alloc=%b credit=%b | d0 cnt=%h free=%b err=%0b | d1 cnt=%h free=%b cong=%0d err=%0b",
                 w, wv, t, a, cr, cnt0, free0, err0, cnt1, free1, cong1, err1);
        check_model();
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, '0);
    endtask

    // Asserts reset mid-cycle; outputs must return to reset values at once.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_not_full0", 32'(nf0), 32'hF);
        check("rst_free0", 32'(free0), 32'hF);
        check("rst_cnt0", 32'(cnt0), 32'h924);
        check("rst_cong0", 32'(cong0), 32'h0);
        check("rst_err0", 32'(err0), 32'h0);
        check("rst_not_full1", 32'(nf1), 32'hF);
        check("rst_free1", 32'(free1), 32'hF);
        check("rst_cnt1", 32'(cnt1), 32'h924);
        check("rst_cong1", 32'(cong1), 32'h0);
        check("rst_err1", 32'(err1), 32'h0);
        $display("reset asserted");
        model_reset();
        we = 1'b0; vc = '0; tail = 1'b0; alloc = '0; credit = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------ directed table
    typedef struct {
        bit           rst;
        bit           w;
        logic [V-1:0] wv;
        bit           t;
        logic [V-1:0] a;
        logic [V-1:0] cr;
        logic [V-1:0] e_nf;
        logic [V-1:0] e_free;
        logic [11:0]  e_cnt;
        bit           e_err;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [V-1:0] rv, ra;
        reset = 1'b1; we = 1'b0; vc = '0; tail = 1'b0; alloc = '0; credit = '0;
        model_reset();
        // Expectations for config 0 (non-atomic, no link delay).
        //            rst  we   vc       tail a        credit   nf       free     cnt      err
        tbl[0]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 12'h924, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b1111, 4'b1101, 12'h924, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b1101, 12'h91C, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b1101, 12'h914, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b1101, 12'h90C, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b1101, 4'b1101, 12'h904, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b1101, 4'b1101, 12'h904, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 12'h924, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b1111, 4'b1011, 12'h924, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 4'b0100, 1'b1, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 12'h8E4, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b1111, 4'b1011, 12'h8E4, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 4'b0100, 1'b1, 4'b0100, 4'b0000, 4'b1111, 4'b1011, 12'h8A4, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0100, 4'b1111, 4'b1011, 12'h8E4, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0100, 4'b1111, 4'b1011, 12'h924, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset.
        do_reset();
        repeat (5) idle();

        // Table: counting down VC1, and non-atomic release / hand-over on VC2.
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            else step(tbl[i].w, tbl[i].wv, tbl[i].t, tbl[i].a, tbl[i].cr);
            check($sformatf("tbl%0d_not_full", i), 32'(nf0), 32'(tbl[i].e_nf));
            check($sformatf("tbl%0d_free", i), 32'(free0), 32'(tbl[i].e_free));
            check($sformatf("tbl%0d_cnt", i), 32'(cnt0), 32'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_err", i), 32'(err0), 32'(tbl[i].e_err));
        end

        // Link delay of two: credit lands three cycles after it is presented.
        do_reset();
        step(1'b0, '0, 1'b0, 4'b0010, '0);
        repeat (4) step(1'b1, 4'b0010, 1'b0, '0, '0);
        check("ld_cnt1_empty", 32'(cnt1[5:3]), 32'd0);
        check("ld_not_full", 32'(nf1), 32'b1101);
        step(1'b0, '0, 1'b0, '0, 4'b0010);
        check("ld_t1", 32'(cnt1[5:3]), 32'd0);
        idle();
        check("ld_t2", 32'(cnt1[5:3]), 32'd0);
        idle();
        check("ld_t3", 32'(cnt1[5:3]), 32'd1);
        step(1'b0, '0, 1'b0, '0, 4'b0010);
        idle();
        step(1'b1, 4'b0010, 1'b0, '0, '0);
        check("ld_cancel", 32'(cnt1[5:3]), 32'd1);
        check("ld_err", 32'(err1), 32'd0);

        // Atomic drain on VC0.
        do_reset();
        step(1'b0, '0, 1'b0, 4'b0001, '0);
        step(1'b1, 4'b0001, 1'b0, '0, '0);
        step(1'b1, 4'b0001, 1'b1, '0, '0);
        check("at_drain_free", 32'(free1[0]), 32'd0);
        check("at_drain_cnt", 32'(cnt1[2:0]), 32'd2);
        step(1'b0, '0, 1'b0, '0, 4'b0001);
        step(1'b0, '0, 1'b0, '0, 4'b0001);
        idle();
        check("at_one_credit_free", 32'(free1[0]), 32'd0);
        check("at_one_credit_cnt", 32'(cnt1[2:0]), 32'd3);
        idle();
        check("at_full_free", 32'(free1[0]), 32'd1);
        check("at_full_cnt", 32'(cnt1[2:0]), 32'd4);
        check("at_no_err", 32'(err1), 32'd0);
        step(1'b0, '0, 1'b0, 4'b0001, '0);
        step(1'b1, 4'b0001, 1'b1, '0, '0);
        check("at_drain2_free", 32'(free1[0]), 32'd0);
        step(1'b0, '0, 1'b0, 4'b0001, '0);
        check("at_alloc_in_drain_err", 32'(err1), 32'd1);
        check("at_nonatomic_ok", 32'(err0), 32'd0);

        // Congestion saturation, then reset in the middle of a burst.
        do_reset();
        step(1'b0, '0, 1'b0, 4'b0001, '0);
        step(1'b0, '0, 1'b0, 4'b0010, '0);
        step(1'b0, '0, 1'b0, 4'b0100, '0);
        check("cong_two", 32'(cong1), 32'd2);
        step(1'b0, '0, 1'b0, 4'b1000, '0);
        check("cong_sat", 32'(cong1), 32'd3);
        step(1'b1, 4'b0001, 1'b0, '0, 4'b0010);
        check("cong_sat_hold", 32'(cong1), 32'd3);
        check("cong_wide", 32'(cong0), 32'd4);
        do_reset();

        // Randomised traffic against the model, with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end else begin
                rv = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
                ra = '0;
                if ($urandom_range(0, 3) == 0)
                    ra = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
                step(1'($urandom), rv, ($urandom_range(0, 2) == 0), ra, 4'($urandom & $urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
